// File: rtl/rx_tlp_trigger.sv
// rx_tlp_trigger: decides when and how many qwords the host-write TLP engine
// must push into the current huge page, and when that page must be closed.
module rx_tlp_trigger #(
  parameter int unsigned BF            = 7,
  parameter int unsigned MAX_QW        = 16,
  parameter int unsigned HP_QW         = 262128,
  parameter int unsigned TLP_TIMEOUT   = 32,
  parameter int unsigned CLOSE_TIMEOUT = 4096
) (
  input  logic          trn_clk,
  input  logic          reset_n,
  input  logic [BF:0]   commited_wr_address,
  input  logic [BF:0]   commited_rd_address,
  output logic          trigger_tlp,
  input  logic          trigger_tlp_ack,
  output logic          send_last_tlp,
  output logic          change_huge_page,
  input  logic          change_huge_page_ack,
  output logic [4:0]    qwords_to_send
);

  localparam int unsigned PW = BF + 1;
  localparam int unsigned TW = $clog2(TLP_TIMEOUT + 1);
  localparam int unsigned CW = $clog2(CLOSE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_COMMIT, WAIT_CHG} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pending_q, pending_prev_q, snap_q, snap_d;
  logic [31:0]   page_used_q, page_used_d;
  logic [TW-1:0] part_timer_q, part_timer_d;
  logic [CW-1:0] idle_timer_q, idle_timer_d;
  logic          trig_q, trig_d, last_q, last_d, chg_q, chg_d;
  logic [4:0]    qw_q, qw_d;

  logic [31:0]   room_c;
  logic [31:0]   pend32_c;
  logic          commit_done_c;

  assign room_c        = 32'(HP_QW) - page_used_q;
  assign pend32_c      = 32'(pending_q);
  assign commit_done_c = (commited_rd_address == (snap_q + PW'(qw_q)));

  // State, request and bookkeeping registers; pending is sampled with one cycle latency.
  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      pending_prev_q <= '0;
      snap_q         <= '0;
      page_used_q    <= '0;
      part_timer_q   <= '0;
      idle_timer_q   <= '0;
      trig_q         <= 1'b0;
      last_q         <= 1'b0;
      chg_q          <= 1'b0;
      qw_q           <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= commited_wr_address - commited_rd_address;
      pending_prev_q <= pending_q;
      snap_q         <= snap_d;
      page_used_q    <= page_used_d;
      part_timer_q   <= part_timer_d;
      idle_timer_q   <= idle_timer_d;
      trig_q         <= trig_d;
      last_q         <= last_d;
      chg_q          <= chg_d;
      qw_q           <= qw_d;
    end
  end

  // Next-state and next-request decision.
  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    page_used_d  = page_used_q;
    part_timer_d = '0;
    idle_timer_d = '0;
    trig_d       = trig_q;
    last_d       = last_q;
    chg_d        = chg_q;
    qw_d         = qw_q;

    unique case (state_q)
      IDLE: begin
        if (room_c == 32'd0) begin
          chg_d   = 1'b1;
          state_d = WAIT_CHG;
        end else if (pend32_c >= room_c && room_c < 32'(MAX_QW)) begin
          last_d  = 1'b1;
          qw_d    = 5'(room_c);
          snap_d  = commited_rd_address;
          state_d = WAIT_CHG;
        end else if (pend32_c >= 32'(MAX_QW)) begin
          trig_d  = 1'b1;
          qw_d    = 5'(MAX_QW);
          snap_d  = commited_rd_address;
          state_d = WAIT_ACK;
        end else if (pend32_c != 32'd0) begin
          // Partial backlog: flush once it has been stable long enough.
          if (pending_q != pending_prev_q) begin
            part_timer_d = '0;
          end else if (part_timer_q == TW'(TLP_TIMEOUT - 1)) begin
            trig_d  = 1'b1;
            qw_d    = (pend32_c < room_c) ? 5'(pend32_c) : 5'(room_c);
            snap_d  = commited_rd_address;
            state_d = WAIT_ACK;
          end else begin
            part_timer_d = part_timer_q + TW'(1);
          end
        end else if (page_used_q != 32'd0) begin
          // Empty buffer on a partly filled page: hand it over after a long idle.
          if (idle_timer_q == CW'(CLOSE_TIMEOUT - 1)) begin
            chg_d   = 1'b1;
            state_d = WAIT_CHG;
          end else begin
            idle_timer_d = idle_timer_q + CW'(1);
          end
        end
      end

      WAIT_ACK: begin
        if (trigger_tlp_ack) begin
          trig_d      = 1'b0;
          page_used_d = page_used_q + 32'(qw_q);
          state_d     = WAIT_COMMIT;
        end
      end

      WAIT_COMMIT: begin
        if (commit_done_c) state_d = IDLE;
      end

      WAIT_CHG: begin
        if (last_q || chg_q) begin
          if (change_huge_page_ack) begin
            last_d      = 1'b0;
            chg_d       = 1'b0;
            page_used_d = '0;
            if (chg_q || commit_done_c) state_d = IDLE;
          end
        end else if (commit_done_c) begin
          // Last TLP acked before its payload was committed.
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign trigger_tlp      = trig_q;
  assign send_last_tlp    = last_q;
  assign change_huge_page = chg_q;
  assign qwords_to_send   = qw_q;

endmodule

// File: tb/tb_rx_tlp_trigger.sv
// Bench for rx_tlp_trigger: three instances with different page sizes, an
// emulated TLP engine, and a request-sequence model derived from page rules.
module tb_rx_tlp_trigger;

  localparam int unsigned BF       = 7;
  localparam int unsigned PW       = BF + 1;
  localparam int unsigned MAX_QW   = 16;
  localparam int unsigned TLP_TO   = 32;
  localparam int unsigned CLOSE_TO = 100;
  localparam int          N        = 3;

  function automatic int unsigned hp_of(input int i);
    case (i)
      1:       return 40;
      2:       return 32;
      default: return 262128;
    endcase
  endfunction

  typedef struct {
    int kind;  // 1 trigger, 2 send_last, 3 change page
    int qw;
  } req_t;

  logic          trn_clk = 1'b0;
  logic          reset_n;
  logic [PW-1:0] wr [N];
  logic [PW-1:0] rd [N];
  logic          tack [N];
  logic          cack [N];
  logic          trig [N];
  logic          last [N];
  logic          chg  [N];
  logic [4:0]    qw   [N];

  int   n_chk = 0;
  int   n_fail = 0;
  int   t_pos = 0;
  int   t_mark = 0;
  int   used_m [N];
  req_t exp_q [$];
  int   gap_q [$];

  always #5 trn_clk = ~trn_clk;
  always @(posedge trn_clk) t_pos <= t_pos + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rx_tlp_trigger #(
      .BF(BF), .MAX_QW(MAX_QW), .HP_QW(hp_of(g)),
      .TLP_TIMEOUT(TLP_TO), .CLOSE_TIMEOUT(CLOSE_TO)
    ) u_dut (
      .trn_clk              (trn_clk),
      .reset_n              (reset_n),
      .commited_wr_address  (wr[g]),
      .commited_rd_address  (rd[g]),
      .trigger_tlp          (trig[g]),
      .trigger_tlp_ack      (tack[g]),
      .send_last_tlp        (last[g]),
      .change_huge_page     (chg[g]),
      .change_huge_page_ack (cack[g]),
      .qwords_to_send       (qw[g])
    );
  end

  function automatic bit any_req(input int idx);
    return trig[idx] || last[idx] || chg[idx];
  endfunction

  function automatic bit req_of(input int idx, input int k);
    return (k == 1) ? trig[idx] : (k == 2) ? last[idx] : chg[idx];
  endfunction

  // Expected request sequence for a burst of amt qwords on instance idx.
  task automatic build(input int idx, input int amt, input bit close);
    int pend = amt;
    int hp = int'(hp_of(idx));
    int room;
    while (pend > 0 || used_m[idx] == hp) begin
      room = hp - used_m[idx];
      if (room == 0) begin
        exp_q.push_back('{3, 0}); used_m[idx] = 0;
      end else if (pend >= room && room < int'(MAX_QW)) begin
        exp_q.push_back('{2, room}); pend -= room; used_m[idx] = 0;
      end else if (pend >= int'(MAX_QW)) begin
        exp_q.push_back('{1, int'(MAX_QW)}); pend -= int'(MAX_QW); used_m[idx] += int'(MAX_QW);
      end else begin
        exp_q.push_back('{1, pend}); used_m[idx] += pend; pend = 0;
      end
    end
    if (close && used_m[idx] > 0) begin
      exp_q.push_back('{3, 0}); used_m[idx] = 0;
    end
  endtask

  // Engine emulation: answer n expected requests and compare each one.
  task automatic serve_n(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      req_t e;
      int cyc, k, q;
      bit bad;
      if (exp_q.size() == 0) break;
      e = exp_q.pop_front();
      cyc = 0;
      @(negedge trn_clk);
      while (!any_req(idx) && cyc < 400) begin
        @(negedge trn_clk); cyc++;
      end
      n_chk++;
      if (!any_req(idx)) begin
        $display("FAIL req_timeout dut%0d: no request seen, expected kind %0d qw %0d", idx, e.kind, e.qw);
        n_fail++; exp_q.delete(); return;
      end
      gap_q.push_back(t_pos - t_mark);
      k = trig[idx] ? 1 : last[idx] ? 2 : 3;
      q = int'(qw[idx]);
      n_chk++;
      if (int'(trig[idx]) + int'(last[idx]) + int'(chg[idx]) != 1) begin
        $display("FAIL req_exclusive dut%0d: trig=%b last=%b chg=%b, required exactly one", idx, trig[idx], last[idx], chg[idx]);
        n_fail++;
      end
      n_chk++;
      if (k != e.kind || (k != 3 && q != e.qw)) begin
        $display("FAIL req_kind dut%0d: got kind %0d qw %0d, expected kind %0d qw %0d", idx, k, q, e.kind, e.qw);
        n_fail++;
      end
      bad = 1'b0;
      repeat ($urandom_range(3, 0)) begin
        @(negedge trn_clk);
        if (!req_of(idx, k) || int'(qw[idx]) != q) bad = 1'b1;
      end
      if (k == 1) begin
        tack[idx] = 1'b1; @(negedge trn_clk); tack[idx] = 1'b0;
        n_chk++;
        if (trig[idx] !== 1'b0) begin
          $display("FAIL trig_drop dut%0d: trigger_tlp=%b after ack, required 0", idx, trig[idx]);
          n_fail++;
        end
        repeat ($urandom_range(5, 0)) begin
          @(negedge trn_clk);
          if (any_req(idx)) bad = 1'b1;
        end
        rd[idx] = rd[idx] + PW'(q);
      end else begin
        if (k == 2) begin
          rd[idx] = rd[idx] + PW'(q);
          repeat ($urandom_range(2, 0)) begin
            @(negedge trn_clk);
            if (!last[idx]) bad = 1'b1;
          end
        end
        cack[idx] = 1'b1; @(negedge trn_clk); cack[idx] = 1'b0;
        n_chk++;
        if (last[idx] !== 1'b0 || chg[idx] !== 1'b0) begin
          $display("FAIL chg_drop dut%0d: last=%b chg=%b after change ack, required 0", idx, last[idx], chg[idx]);
          n_fail++;
        end
      end
      t_mark = t_pos;
      n_chk++;
      if (bad) begin
        $display("FAIL req_hold dut%0d: request/qw unstable or stale request, kind %0d qw %0d", idx, k, q);
        n_fail++;
      end
    end
  endtask

  task automatic check_gap(input string name, input int pos, input int lo, input int hi);
    n_chk++;
    if (pos >= gap_q.size()) begin
      $display("FAIL %s: no timing sample %0d, required gap %0d..%0d", name, pos, lo, hi);
      n_fail++;
    end else if (gap_q[pos] < lo || gap_q[pos] > hi) begin
      $display("FAIL %s: gap %0d cycles, required %0d..%0d", name, gap_q[pos], lo, hi);
      n_fail++;
    end
  endtask

  task automatic start_test();
    gap_q.delete();
    exp_q.delete();
    t_mark = t_pos;
  endtask

  task automatic test_reset();
    int seen = 0;
    reset_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge trn_clk);
      for (int i = 0; i < N; i++) begin
        wr[i] = PW'($urandom); rd[i] = PW'($urandom);
        tack[i] = 1'($urandom); cack[i] = 1'($urandom);
      end
      n_chk++;
      if (trig[0] !== 1'b0 || last[0] !== 1'b0 || chg[0] !== 1'b0 || qw[0] !== 5'd0) begin
        $display("FAIL reset_outputs: trig=%b last=%b chg=%b qw=%0d, required all 0", trig[0], last[0], chg[0], qw[0]);
        n_fail++;
      end
    end
    for (int i = 0; i < N; i++) begin
      wr[i] = '0; rd[i] = '0; tack[i] = 1'b0; cack[i] = 1'b0; used_m[i] = 0;
    end
    @(negedge trn_clk);
    reset_n = 1'b1;
    repeat (10000) begin
      @(negedge trn_clk);
      for (int i = 0; i < N; i++) if (any_req(i) || qw[i] !== 5'd0) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      $display("FAIL reset_quiet: %0d request cycles with empty buffer, required 0", seen);
      n_fail++;
    end
  endtask

  task automatic test_bulk();
    start_test();
    wr[0] = wr[0] + PW'(40);
    build(0, 40, 1'b0);
    serve_n(0, 3);
    check_gap("bulk_partial_timeout", 2, int'(TLP_TO) - 1, int'(TLP_TO) + 3);
    n_chk++;
    if (g_dut[0].u_dut.page_used_q !== 32'd40) begin
      $display("FAIL bulk_page_used: %0d, required 40", g_dut[0].u_dut.page_used_q);
      n_fail++;
    end
    gap_q.delete();
    build(0, 0, 1'b1);
    serve_n(0, 1);
    check_gap("bulk_idle_close", 0, int'(CLOSE_TO) - 1, int'(CLOSE_TO) + 3);
  endtask

  task automatic test_page_tail();
    start_test();
    wr[1] = wr[1] + PW'(64);
    build(1, 64, 1'b1);
    serve_n(1, 6);
  endtask

  task automatic test_exact_fill();
    start_test();
    wr[2] = wr[2] + PW'(48);
    build(2, 48, 1'b1);
    serve_n(2, 5);
  endtask

  task automatic test_idle_close();
    int seen = 0;
    start_test();
    wr[0] = wr[0] + PW'(5);
    build(0, 5, 1'b0);
    serve_n(0, 1);
    check_gap("idle_partial_flush", 0, int'(TLP_TO) - 1, int'(TLP_TO) + 3);
    repeat (60) begin
      @(negedge trn_clk);
      if (any_req(0)) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      $display("FAIL idle_early_close: %0d request cycles before timeout, required 0", seen);
      n_fail++;
    end
    start_test();
    wr[0] = wr[0] + PW'(3);
    build(0, 3, 1'b1);
    serve_n(0, 2);
    check_gap("idle_restart_close", 1, int'(CLOSE_TO) - 1, int'(CLOSE_TO) + 3);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int idx = int'($urandom_range(2, 0));
      int amt = int'($urandom_range(60, 1));
      start_test();
      wr[idx] = wr[idx] + PW'(amt);
      build(idx, amt, 1'b1);
      serve_n(idx, exp_q.size());
    end
  endtask

  task automatic test_wrap_reset();
    int cyc = 0;
    start_test();
    @(negedge trn_clk);
    wr[0] = PW'(252); rd[0] = PW'(252);
    repeat (5) @(negedge trn_clk);
    wr[0] = wr[0] + PW'(20);
    while (!trig[0] && cyc < 50) begin
      @(negedge trn_clk); cyc++;
    end
    n_chk++;
    if (trig[0] !== 1'b1 || qw[0] !== 5'd16) begin
      $display("FAIL wrap_trigger: trig=%b qw=%0d, required 1 and 16", trig[0], qw[0]);
      n_fail++;
    end
    tack[0] = 1'b1; @(negedge trn_clk); tack[0] = 1'b0;
    @(negedge trn_clk);
    reset_n = 1'b0;
    @(posedge trn_clk); #1;
    n_chk++;
    if (trig[0] !== 1'b0 || last[0] !== 1'b0 || chg[0] !== 1'b0 || qw[0] !== 5'd0) begin
      $display("FAIL midreset_outputs: trig=%b last=%b chg=%b qw=%0d, required all 0", trig[0], last[0], chg[0], qw[0]);
      n_fail++;
    end
    @(negedge trn_clk);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) used_m[i] = 0;
    t_mark = t_pos;
    build(0, 20, 1'b1);
    serve_n(0, 3);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      wr[i] = '0; rd[i] = '0; tack[i] = 1'b0; cack[i] = 1'b0; used_m[i] = 0;
    end
    reset_n = 1'b0;
    test_reset();
    test_bulk();
    test_page_tail();
    test_exact_fill();
    test_idle_close();
    test_random();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_tlp_trigger.md
Name: rx_tlp_trigger

Overview:
- Upstream control stage for the host-write TLP engine.
- Watches the RX packet buffer: producer commit pointer (MAC side) versus consumer commit pointer (returned by the TLP engine).
- Decides when, and how many qwords, the engine must write to the current huge page; asks for a huge-page change when the page is full or has gone idle.
- Drives trigger_tlp / send_last_tlp / change_huge_page / qwords_to_send; consumes the engine's acks and commited_rd_address.

Parameters:
- MAX_QW, 16, maximum TLP payload in qwords (128 B); must be ≤16.
- HP_QW, 262128, usable qwords per huge page (2 MiB/8 minus 16-qword header area).
- TLP_TIMEOUT, 32, cycles a partial (<MAX_QW) backlog waits before being flushed.
- CLOSE_TIMEOUT, 4096, idle cycles after which a non-empty page is handed to the host.

Ports:
- trn_clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- commited_wr_address  in  `BF+1  producer commit pointer (qword units), synchronous to trn_clk
- commited_rd_address  in  `BF+1  consumer commit pointer from TLP engine
- trigger_tlp  out  1  request normal TLP of qwords_to_send
- trigger_tlp_ack  in  1  one-cycle pulse, engine accepted trigger
- send_last_tlp  out  1  request final TLP of page, followed by page change
- change_huge_page  out  1  request page close without payload TLP
- change_huge_page_ack  in  1  one-cycle pulse, engine issued close TLP
- qwords_to_send  out  5  payload size for pending request, 1..MAX_QW

Behaviour:
- Reset: all outputs 0; FSM IDLE; page_used=0; timers=0.
- Request ownership: all three requests are exclusive.
  - qwords_to_send stays stable from request assertion until the request completes (see WAIT_COMMIT, WAIT_CHG); the engine samples it every cycle while idle.
- Widths:
  - pending = commited_wr_address − commited_rd_address, modulo 2^(`BF+1), registered once (1-cycle latency). Wrap of either pointer is legal.
  - room = HP_QW − page_used, 32-bit.
- IDLE (evaluated on registered pending, priority top-down):
  - room==0 → assert change_huge_page → WAIT_CHG.
  - pending≥room and room<MAX_QW and room>0 → send_last_tlp, qwords_to_send=room, snapshot rd_ptr → WAIT_CHG.
  - pending≥MAX_QW → trigger_tlp, qwords=MAX_QW, snapshot → WAIT_ACK.
  - 0<pending<MAX_QW:
    - part_timer increments; reset to 0 whenever pending changes.
    - At part_timer==TLP_TIMEOUT−1: trigger_tlp with qwords=min(pending,room) → WAIT_ACK.
  - pending==0 and page_used>0:
    - idle_timer increments; reaching CLOSE_TIMEOUT−1 asserts change_huge_page → WAIT_CHG.
  - Timers clear on leaving IDLE.
- WAIT_ACK:
  - On trigger_tlp_ack: drop trigger_tlp; page_used += qwords_to_send → WAIT_COMMIT.
  - Ack arriving same cycle as assertion is not possible (engine registers); ack in any state other than WAIT_ACK is ignored.
- WAIT_COMMIT:
  - Stay until commited_rd_address == snapshot + qwords_to_send (mod) → IDLE.
  - Prevents re-triggering on a stale pending value.
- WAIT_CHG:
  - Hold send_last_tlp or change_huge_page until change_huge_page_ack.
  - Then drop the request; page_used=0; → IDLE.
  - For send_last_tlp, also wait until commit equals snapshot+qwords before IDLE (commit precedes ack in the engine, so normally already true).
- Simultaneous: the engine gives change priority; this block never raises trigger_tlp while in WAIT_CHG.
- pending > buffer size is impossible by construction; no check.
- Reset mid-operation: immediate return to reset values. The engine is reset by the same link-down, so no recovery handshake is needed.

Test Plan:
- Reset: hold reset_n=0, toggle inputs → all outputs 0. Release, pointers equal → no request for 10000 cycles (page_used=0, so no close).
- Bulk: wr ptr +40 → trigger qw=16.
  - Ack; rd +16 after 5 cycles → second trigger qw=16.
  - Commit → remaining 8 wait exactly TLP_TIMEOUT cycles → trigger qw=8.
  - page_used=40.
- Page tail, HP_QW=40: wr +64 → two TLPs of 16, then send_last_tlp qw=8.
  - Held through engine's TLP until change ack; page_used→0.
  - Next trigger qw=16 from remaining 24.
- Exact fill, HP_QW=32: wr +48 → two 16-qword TLPs, then change_huge_page alone (no send_last).
  - After ack, trigger qw=16.
- Idle close, CLOSE_TIMEOUT=100: wr +5 → flush qw=5 after timeout, commit.
  - change_huge_page exactly 100 cycles later; new write before expiry restarts timer.
- Pointer wrap: pointers near 2^(`BF+1)−4, wr wraps +20 → pending=20, trigger qw=16. Reset asserted in WAIT_COMMIT → outputs 0 next edge.
